// File: rtl/voice_mixer_if.sv
// Bus bundle between the voice generators / codec control and voice_mixer.
// master drives the frame request and voice data; slave is the mixer.
interface voice_mixer_if #(
  parameter int unsigned NUM_VOICES   = 3,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ATTEN_WIDTH  = 3
);
  logic                                 new_frame;
  logic [NUM_VOICES*SAMPLE_WIDTH-1:0]   voice_samples;
  logic [NUM_VOICES-1:0]                voice_enable;
  logic [NUM_VOICES*ATTEN_WIDTH-1:0]    voice_atten;
  logic [SAMPLE_WIDTH-1:0]              sample_out;
  logic                                 sample_done;
  logic                                 busy;
  logic                                 clip;

  modport master (
    output new_frame, voice_samples, voice_enable, voice_atten,
    input  sample_out, sample_done, busy, clip
  );

  modport slave (
    input  new_frame, voice_samples, voice_enable, voice_atten,
    output sample_out, sample_done, busy, clip
  );
endinterface

// File: rtl/voice_mixer.sv
// N-voice mixer: snapshots voices on new_frame, accumulates one voice per cycle.
// Define VOICE_MIXER_SATURATE_EN for clamp-and-flag output; otherwise the sum is scaled down.
module voice_mixer #(
  parameter int unsigned NUM_VOICES   = 3,
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned ATTEN_WIDTH  = 3
) (
  input  logic          clk,
  input  logic          reset,
  voice_mixer_if.slave  bus
);

  localparam int unsigned ACC_W = SAMPLE_WIDTH + $clog2(NUM_VOICES + 1);
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

`ifdef VOICE_MIXER_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(SAMPLE_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`else
  localparam int unsigned SCALE_SHIFT = $clog2(NUM_VOICES);
`endif

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic signed [ACC_W-1:0]        acc_q, acc_d;
  logic signed [SAMPLE_WIDTH-1:0] snap_sample_q [NUM_VOICES];
  logic signed [SAMPLE_WIDTH-1:0] snap_sample_d [NUM_VOICES];
  logic [ATTEN_WIDTH-1:0]         snap_atten_q  [NUM_VOICES];
  logic [ATTEN_WIDTH-1:0]         snap_atten_d  [NUM_VOICES];
  logic [NUM_VOICES-1:0]          snap_enable_q, snap_enable_d;
  logic [SAMPLE_WIDTH-1:0]        sample_out_q, sample_out_d;
  logic                           sample_done_q, sample_done_d;
  logic                           busy_q, busy_d;
  logic                           clip_q, clip_d;

  logic signed [ACC_W-1:0]        term;
  logic [SAMPLE_WIDTH-1:0]        mix_out;
  logic                           mix_clip;

  // Attenuated contribution of the voice currently selected by idx_q
  always_comb begin
    term = ACC_W'(snap_sample_q[idx_q] >>> snap_atten_q[idx_q]);
  end

  // Final output conversion from the full-width accumulator
  always_comb begin
    mix_out  = SAMPLE_WIDTH'(acc_q);
    mix_clip = 1'b0;
`ifdef VOICE_MIXER_SATURATE_EN
    if (acc_q > SAT_MAX) begin
      mix_out  = SAMPLE_WIDTH'(SAT_MAX);
      mix_clip = 1'b1;
    end else if (acc_q < SAT_MIN) begin
      mix_out  = SAMPLE_WIDTH'(SAT_MIN);
      mix_clip = 1'b1;
    end
`else
    mix_out = SAMPLE_WIDTH'(acc_q >>> SCALE_SHIFT);
`endif
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    snap_sample_d = snap_sample_q;
    snap_atten_d  = snap_atten_q;
    snap_enable_d = snap_enable_q;
    sample_out_d  = sample_out_q;
    clip_d        = clip_q;
    sample_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.new_frame) begin
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            snap_sample_d[i] = bus.voice_samples[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
            snap_atten_d[i]  = bus.voice_atten[i*ATTEN_WIDTH +: ATTEN_WIDTH];
          end
          snap_enable_d = bus.voice_enable;
          acc_d         = '0;
          idx_d         = '0;
          state_d       = ACCUM;
        end
      end
      ACCUM: begin
        if (snap_enable_q[idx_q]) begin
          acc_d = acc_q + term;
        end
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        sample_out_d  = mix_out;
        clip_d        = mix_clip;
        sample_done_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      snap_enable_q <= '0;
      sample_out_q  <= '0;
      sample_done_q <= 1'b0;
      busy_q        <= 1'b0;
      clip_q        <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        snap_sample_q[i] <= '0;
        snap_atten_q[i]  <= '0;
      end
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      snap_sample_q <= snap_sample_d;
      snap_atten_q  <= snap_atten_d;
      snap_enable_q <= snap_enable_d;
      sample_out_q  <= sample_out_d;
      sample_done_q <= sample_done_d;
      busy_q        <= busy_d;
      clip_q        <= clip_d;
    end
  end

  assign bus.sample_out  = sample_out_q;
  assign bus.sample_done = sample_done_q;
  assign bus.busy        = busy_q;
  assign bus.clip        = clip_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Self-checking bench for voice_mixer: directed vector table, corner sequences,
// and randomized mixes checked against an arithmetic reference model.
module tb_voice_mixer;

`ifdef VOICE_MIXER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  voice_mixer_if #(.NUM_VOICES(3), .SAMPLE_WIDTH(16), .ATTEN_WIDTH(3)) bus3 ();
  voice_mixer_if #(.NUM_VOICES(8), .SAMPLE_WIDTH(16), .ATTEN_WIDTH(3)) bus8 ();

  voice_mixer #(.NUM_VOICES(3), .SAMPLE_WIDTH(16), .ATTEN_WIDTH(3)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  voice_mixer #(.NUM_VOICES(8), .SAMPLE_WIDTH(16), .ATTEN_WIDTH(3)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic signed [15:0] s0, s1, s2;
    logic [2:0]         en;
    logic [2:0]         a0, a1, a2;
    logic signed [15:0] exp_sat;
    logic               clip_sat;
    logic signed [15:0] exp_trunc;
  } vec_t;

  function automatic vec_t mk(int s0, int s1, int s2, int en, int a0, int a1, int a2,
                              int es, int cs, int et);
    vec_t v;
    v.s0 = 16'(s0); v.s1 = 16'(s1); v.s2 = 16'(s2);
    v.en = 3'(en);
    v.a0 = 3'(a0); v.a1 = 3'(a1); v.a2 = 3'(a2);
    v.exp_sat = 16'(es); v.clip_sat = 1'(cs); v.exp_trunc = 16'(et);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of shifted enabled voices, then clamp or scale
  function automatic void ref_mix(input int n, input int smp[8], input bit en[8],
                                  input int at[8], output int out, output int clp);
    int sum;
    logic signed [15:0] t;
    sum = 0;
    for (int i = 0; i < n; i++) if (en[i]) sum += (smp[i] >>> at[i]);
    clp = 0;
    if (SAT) begin
      if (sum > 32767) begin out = 32767; clp = 1; end
      else if (sum < -32768) begin out = -32768; clp = 1; end
      else out = sum;
    end else begin
      t = 16'(sum >>> $clog2(n));
      out = int'(t);
    end
  endfunction

  task automatic drive3(input vec_t v);
    bus3.voice_samples = {v.s2, v.s1, v.s0};
    bus3.voice_enable  = v.en;
    bus3.voice_atten   = {v.a2, v.a1, v.a0};
  endtask

  // Pulse new_frame into the 3-voice DUT and wait (bounded) for sample_done
  task automatic mix3(output int lat, output int out, output int clp, output int busy_n);
    bus3.new_frame = 1'b1;
    @(posedge clk); #1;
    bus3.new_frame = 1'b0;
    busy_n = bus3.busy ? 1 : 0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus3.sample_done) begin lat = k; break; end
      if (bus3.busy) busy_n++;
    end
    out = int'($signed(bus3.sample_out));
    clp = int'(bus3.clip);
  endtask

  task automatic mix8(output int lat, output int out, output int clp);
    bus8.new_frame = 1'b1;
    @(posedge clk); #1;
    bus8.new_frame = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus8.sample_done) begin lat = k; break; end
    end
    out = int'($signed(bus8.sample_out));
    clp = int'(bus8.clip);
  endtask

  vec_t vecs [10];

  initial begin
    int lat, out, clp, busy_n, dones, exp_out, exp_clp;
    int smp [8];
    bit en [8];
    int at [8];
    logic signed [15:0] r;

    n_cmp = 0;
    n_bad = 0;
    vecs[0] = mk(1000, 2000, -500, 7, 0, 0, 0, 2500, 0, 625);
    vecs[1] = mk(30000, 30000, 0, 7, 0, 0, 0, 32767, 1, 15000);
    vecs[2] = mk(-30000, -30000, -30000, 7, 0, 0, 0, -32768, 1, -22500);
    vecs[3] = mk(-1, 0, 0, 7, 0, 0, 0, -1, 0, -1);
    vecs[4] = mk(9999, 4000, 9999, 2, 0, 2, 0, 1000, 0, 250);
    vecs[5] = mk(9999, -4000, 9999, 2, 0, 2, 0, -1000, 0, -250);
    vecs[6] = mk(5, 6, 7, 0, 0, 0, 0, 0, 0, 0);
    vecs[7] = mk(32767, 32767, 32767, 7, 7, 7, 7, 765, 0, 191);
    vecs[8] = mk(-7, 1234, 555, 1, 1, 0, 0, -4, 0, -1);
    vecs[9] = mk(1000, -2000, 300, 7, 1, 3, 0, 550, 0, 137);

    bus3.new_frame = 1'b0; bus3.voice_samples = '0; bus3.voice_enable = '0; bus3.voice_atten = '0;
    bus8.new_frame = 1'b0; bus8.voice_samples = '0; bus8.voice_enable = '0; bus8.voice_atten = '0;

    // Reset held four cycles
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check("rst_sample_out", int'(bus3.sample_out), 0);
    check("rst_sample_done", int'(bus3.sample_done), 0);
    check("rst_busy", int'(bus3.busy), 0);
    check("rst_clip", int'(bus3.clip), 0);
    check("rst_busy8", int'(bus8.busy), 0);

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      drive3(vecs[i]);
      mix3(lat, out, clp, busy_n);
      check($sformatf("vec%0d_out", i), out, SAT ? int'(vecs[i].exp_sat) : int'(vecs[i].exp_trunc));
      check($sformatf("vec%0d_clip", i), clp, SAT ? int'(vecs[i].clip_sat) : 0);
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_busy_cycles", i), busy_n, 4);
    end

    // sample_done is a single-cycle pulse and the output holds afterwards
    @(posedge clk); #1;
    check("done_pulse_width", int'(bus3.sample_done), 0);
    check("out_hold", int'($signed(bus3.sample_out)), SAT ? 550 : 137);
    repeat (3) @(posedge clk);
    #1 check("out_hold_later", int'($signed(bus3.sample_out)), SAT ? 550 : 137);

    // Back-to-back: second new_frame arrives in the sample_done cycle
    drive3(vecs[1]);
    mix3(lat, out, clp, busy_n);
    drive3(vecs[0]);
    mix3(lat, out, clp, busy_n);
    check("b2b_latency", lat, 4);
    check("b2b_out", out, SAT ? 2500 : 625);
    check("b2b_clip", clp, 0);

    // Snapshot isolation; new_frame during ACCUM and during FINISH both ignored
    drive3(vecs[0]);
    bus3.new_frame = 1'b1;
    @(posedge clk); #1;
    bus3.voice_samples = {16'sd7777, 16'sd7777, 16'sd7777};
    bus3.voice_atten   = '0;
    dones = 0;
    out = 0;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk); #1;
      if (bus3.sample_done) begin dones++; out = int'($signed(bus3.sample_out)); end
      bus3.new_frame = (k == 3);
    end
    check("snap_done_count", dones, 1);
    check("snap_out", out, SAT ? 2500 : 625);

    // Reset asserted mid-accumulation aborts without sample_done
    drive3(vecs[1]);
    bus3.new_frame = 1'b1;
    @(posedge clk); #1;
    bus3.new_frame = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    dones = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus3.sample_done) dones++;
      @(posedge clk); #1;
    end
    check("abort_no_done", dones, 0);
    check("abort_sample_out", int'(bus3.sample_out), 0);
    check("abort_busy", int'(bus3.busy), 0);
    check("abort_clip", int'(bus3.clip), 0);

    // Randomized mixes against the reference model
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 8; i++) begin
        r = 16'($urandom);
        smp[i] = int'(r);
        en[i]  = 1'($urandom);
        at[i]  = int'($urandom_range(0, 7));
      end
      for (int i = 0; i < 3; i++) begin
        bus3.voice_samples[i*16 +: 16] = 16'(smp[i]);
        bus3.voice_enable[i]           = en[i];
        bus3.voice_atten[i*3 +: 3]     = 3'(at[i]);
      end
      ref_mix(3, smp, en, at, exp_out, exp_clp);
      mix3(lat, out, clp, busy_n);
      check($sformatf("rand%0d_out", it), out, exp_out);
      check($sformatf("rand%0d_clip", it), clp, exp_clp);
      check($sformatf("rand%0d_latency", it), lat, 4);
    end

    // Eight-voice instance: latency NUM_VOICES+1
    bus8.voice_enable = 8'hFF;
    bus8.voice_atten  = '0;
    for (int i = 0; i < 8; i++) bus8.voice_samples[i*16 +: 16] = 16'sd100;
    mix8(lat, out, clp);
    check("v8_latency", lat, 9);
    check("v8_out", out, SAT ? 800 : 100);
    check("v8_clip", clp, 0);
    for (int i = 0; i < 8; i++) bus8.voice_samples[i*16 +: 16] = 16'sd30000;
    mix8(lat, out, clp);
    check("v8_big_out", out, SAT ? 32767 : 30000);
    check("v8_big_clip", clp, SAT ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Parametrised N-voice audio mixer between the per-voice note/sample generators and the AC97 codec interface. On each codec sample-accept pulse (`new_frame`) it snapshots all voice samples, sums the enabled ones with per-voice attenuation over a time-multiplexed accumulator (one voice per cycle), and registers a single signed sample for `PCM_Playback_Left/Right`. It replaces the fixed three-voice summing in the music player with a configurable voice count, per-voice enable/attenuation, and overflow handling.

## Interface

Parameters:
- `NUM_VOICES`, 3, number of voices mixed (>= 1)
- `SAMPLE_WIDTH`, 16, signed two's-complement width of each voice and of the output
- `ATTEN_WIDTH`, 3, width of per-voice attenuation (arithmetic right-shift amount)

Ports:
- `clk`  in  1  system clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `new_frame`  in  1  codec accepted a sample; starts mixing the next one
- `voice_samples`  in  NUM_VOICES*SAMPLE_WIDTH  voice i at `[i*SAMPLE_WIDTH +: SAMPLE_WIDTH]`, signed
- `voice_enable`  in  NUM_VOICES  bit i = 1 includes voice i
- `voice_atten`  in  NUM_VOICES*ATTEN_WIDTH  voice i shift at `[i*ATTEN_WIDTH +: ATTEN_WIDTH]`
- `sample_out`  out  SAMPLE_WIDTH  mixed sample, registered, held until next mix completes
- `sample_done`  out  1  one-cycle pulse when `sample_out` updates
- `busy`  out  1  high while a mix is in progress
- `clip`  out  1  valid with `sample_done`; 1 if the result was saturated

## Operation

- FSM states: IDLE, ACCUM, FINISH.
- IDLE: on `new_frame`=1, snapshot `voice_samples`, `voice_enable`, `voice_atten` into internal registers; clear accumulator; voice index = 0; go ACCUM.
- ACCUM: each cycle add `snap_sample[idx] >>> snap_atten[idx]` (arithmetic, sign-preserving) if `snap_enable[idx]`, else add 0; idx++. After idx = NUM_VOICES-1 is added, go FINISH.
- FINISH: compute output from accumulator, register `sample_out`, `clip`, pulse `sample_done`; go IDLE.
- Accumulator width: SAMPLE_WIDTH + $clog2(NUM_VOICES+1), signed; never wraps internally.
- `busy` = 1 in ACCUM and FINISH.
- `new_frame` while `busy`: ignored, no queueing; the mix in progress is unaffected.
- Input changes after the snapshot edge do not affect the current result.
- All voices disabled: result 0, `clip` 0.

## Timing

- Reset values: `sample_out` 0, `sample_done` 0, `busy` 0, `clip` 0, state IDLE, accumulator 0.
- `new_frame` sampled high at edge E0 -> ACCUM edges E1..E(NUM_VOICES) -> outputs registered at E(NUM_VOICES+1); `sample_done` high for exactly the following cycle. Latency NUM_VOICES+1 edges.
- `new_frame` coincident with FINISH is ignored; `new_frame` in the cycle `sample_done` is high (state IDLE) is accepted.
- Reset asserted mid-mix: abort at that edge, return to reset values, no `sample_done`.
- `sample_out` holds its value between `sample_done` pulses; `clip` holds with it.

## Configuration

- `VOICE_MIXER_SATURATE_EN` defined: output = accumulator clamped to [-2^(SAMPLE_WIDTH-1), 2^(SAMPLE_WIDTH-1)-1]; `clip` = 1 when clamping occurred.
- Undefined: output = accumulator >>> $clog2(NUM_VOICES) (arithmetic, truncating toward -inf), low SAMPLE_WIDTH bits; cannot overflow; `clip` tied 0.

## Test plan

NUM_VOICES=3, SAMPLE_WIDTH=16, ATTEN_WIDTH=3 unless stated.
- Reset held 4 cycles, then released -> `sample_out`=0, `sample_done`=0, `busy`=0, `clip`=0; reset during ACCUM -> no `sample_done`, outputs 0.
- SATURATE_EN: samples 1000, 2000, -500, enable 3'b111, atten 0, `new_frame` pulse -> `sample_done` 4 edges later, `sample_out`=2500, `clip`=0; `busy` high for 4 cycles.
- SATURATE_EN: 30000, 30000, 0 -> 32767, `clip`=1; -30000 x3 -> -32768, `clip`=1.
- SATURATE_EN undefined: 1000, 2000, -500 -> 625; -1, 0, 0 -> -1; `clip`=0 always.
- Enable 3'b010, voice1=4000 atten 2, voices 0/2 = 9999 -> 1000; voice1=-4000 atten 2 -> -1000.
- Change `voice_samples` and pulse `new_frame` on cycle after acceptance -> result reflects snapshot, second pulse ignored, only one `sample_done`; NUM_VOICES=8 build with eight samples of 100 -> 800, latency 9 edges.
